// File: rtl/state_seq_checker.sv
// state_seq_checker
//   Receive-side checker for a free-running 2-bit cyclic state bus (00->01->10->11->00).
//   It hunts for the stream and verifies a run of correct transitions before declaring lock.
//   While locked it flags every out-of-sequence sample. It also counts sequence errors
//   (saturating) and completed wraps (modulo).
//
//   Optional feature macro: STICKY_ERR_EN
//     Adds an err_sticky output. It is set by any seq_error and held until clear or reset.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   state_in     in   observed 2-bit state
//   state_valid  in   state_in is sampled this cycle when high
//   clear        in   synchronous clear of err_count / wrap_count (and err_sticky)
//   locked       out  high in LOCKED or SLIP
//   seq_error    out  one-cycle pulse per mismatch while locked
//   expected     out  predicted next state_in (last accepted + 1, mod 4)
//   err_count    out  saturating count of seq_error pulses
//   wrap_count   out  count of 11->00 transitions seen while locked (wraps)
//   err_sticky   out  (STICKY_ERR_EN only) sticky error flag
//
// state  | meaning
// HUNT   | no reference yet; the next valid sample seeds 'last'
// VERIFY | counting consecutive correct transitions toward lock
// LOCKED | in sequence; a mismatch raises seq_error and moves to SLIP (or HUNT)
// SLIP   | locked but recently mismatched; a match restores LOCKED
module state_seq_checker #(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 2,
  parameter int ERR_CNT_W     = 8,
  parameter int WRAP_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state_in,
  input  logic                  state_valid,
  input  logic                  clear,
  output logic                  locked,
  output logic                  seq_error,
  output logic [1:0]            expected,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
`ifdef STICKY_ERR_EN
  ,
  output logic                  err_sticky
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);
  // good_cnt holding LOCK_COUNT-1 means the current match completes the lock run.
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRORS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_t;

  state_t          state_q, state_nxt;
  logic [1:0]      last_q;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [BW-1:0]   bad_cnt, bad_nxt;
  logic            match;
  logic            err_hit;
  logic            wrap_hit;

  assign match = (state_in == 2'(last_q + 2'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state_q  <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    err_hit   = 1'b0;
    wrap_hit  = 1'b0;
    if (state_valid) begin
      case (state_q)
        HUNT: begin
          state_nxt = VERIFY;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
        VERIFY: begin
          if (match) begin
            if (good_cnt == GOOD_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + GW'(1);
            end
          end else begin
            // Resync: the mismatching sample becomes the new reference.
            good_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_hit = (last_q == 2'b11) && (state_in == 2'b00);
          end else begin
            err_hit = 1'b1;
            bad_nxt = BW'(1);
            if (UNLOCK_ERRORS == 1) begin
              state_nxt = HUNT;
            end else begin
              state_nxt = SLIP;
            end
          end
        end
        SLIP: begin
          if (match) begin
            wrap_hit  = (last_q == 2'b11) && (state_in == 2'b00);
            state_nxt = LOCKED;
            bad_nxt   = '0;
          end else begin
            err_hit = 1'b1;
            if (bad_cnt >= BAD_LAST) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + BW'(1);
            end
          end
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 2'b00;
      expected   <= 2'b00;
      locked     <= 1'b0;
      seq_error  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      if (state_valid) begin
        last_q   <= state_in;
        expected <= 2'(state_in + 2'd1);
      end
      locked    <= (state_nxt == LOCKED) || (state_nxt == SLIP);
      seq_error <= err_hit;
      if (clear) begin
        err_count <= '0;
      end else if (err_hit && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      if (clear) begin
        wrap_count <= '0;
      end else if (wrap_hit) begin
        wrap_count <= wrap_count + WRAP_CNT_W'(1);
      end
    end
  end

`ifdef STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (clear) begin
      err_sticky <= 1'b0;
    end else if (err_hit) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_state_seq_checker.sv
// Bench for state_seq_checker. A reference model runs alongside the stimulus: each driven
// cycle pushes the predicted outputs into a queue. That entry is popped and compared after
// the next rising edge. Directed phases follow the test plan, and a random phase follows them.
module tb_state_seq_checker;

  localparam int LC = 4;
  localparam int UE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state_in = 2'b00;
  logic        state_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        seq_error;
  logic [1:0]  expected;
  logic [7:0]  err_count;
  logic [15:0] wrap_count;
`ifdef STICKY_ERR_EN
  logic        err_sticky;
`endif

  state_seq_checker #(
    .LOCK_COUNT(LC), .UNLOCK_ERRORS(UE), .ERR_CNT_W(8), .WRAP_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
    .clear(clear), .locked(locked), .seq_error(seq_error), .expected(expected),
    .err_count(err_count), .wrap_count(wrap_count)
`ifdef STICKY_ERR_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        se;
    logic [1:0]  ex;
    logic [7:0]  ec;
    logic [15:0] wc;
    logic        st;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 HUNT, 1 VERIFY, 2 LOCKED, 3 SLIP
  int         m_state;
  logic [1:0] m_last;
  int         m_good;
  int         m_bad;
  exp_t       m_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = 2'b00; m_good = 0; m_bad = 0;
    m_out = '{lk: 1'b0, se: 1'b0, ex: 2'b00, ec: 8'd0, wc: 16'd0, st: 1'b0};
  endtask

  task automatic model_step(input logic v, input logic [1:0] s, input logic c);
    logic err, wrap, match;
    err = 1'b0; wrap = 1'b0;
    match = (s == 2'(m_last + 2'd1));
    if (v) begin
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (match) begin
            m_good++;
            if (m_good >= LC) begin m_state = 2; m_good = 0; end
          end else m_good = 0;
        end
        2: begin
          if (!match) begin
            err = 1'b1; m_bad = 1;
            m_state = (UE == 1) ? 0 : 3;
          end else wrap = (m_last == 2'b11);
        end
        default: begin
          if (match) begin
            wrap = (m_last == 2'b11); m_state = 2; m_bad = 0;
          end else begin
            err = 1'b1; m_bad++;
            if (m_bad >= UE) begin m_state = 0; m_bad = 0; end
          end
        end
      endcase
      m_last = s;
      m_out.ex = 2'(s + 2'd1);
    end
    m_out.se = err;
    m_out.lk = (m_state == 2) || (m_state == 3);
    if (c) begin
      m_out.ec = 8'd0; m_out.wc = 16'd0; m_out.st = 1'b0;
    end else begin
      if (err && m_out.ec != 8'hFF) m_out.ec = m_out.ec + 8'd1;
      if (wrap) m_out.wc = m_out.wc + 16'd1;
      if (err) m_out.st = 1'b1;
    end
  endtask

  // Drive one cycle from posedge+1, then compare after the following edge.
  task automatic step(input logic v, input logic [1:0] s, input logic c);
    exp_t e;
    state_valid = v; state_in = s; clear = c;
    model_step(v, s, c);
    sb.push_back(m_out);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq("locked", 32'(locked), 32'(e.lk));
    check_eq("seq_error", 32'(seq_error), 32'(e.se));
    check_eq("expected", 32'(expected), 32'(e.ex));
    check_eq("err_count", 32'(err_count), 32'(e.ec));
    check_eq("wrap_count", 32'(wrap_count), 32'(e.wc));
`ifdef STICKY_ERR_EN
    check_eq("err_sticky", 32'(err_sticky), 32'(e.st));
`endif
    state_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    logic [1:0] l;
    logic [1:0] s;
    logic       v;
    logic       c;
    int         se_seen;
    model_reset();
    #12;
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_expected", 32'(expected), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_wrap", 32'(wrap_count), 32'd0);
    check_eq("rst_seq_error", 32'(seq_error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: acquire lock on 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'(i), 1'b0);
      if (i == 3) check_eq("t1_not_yet_locked", 32'(locked), 32'd0);
    end
    check_eq("t1_locked", 32'(locked), 32'd1);
    check_eq("t1_expected", 32'(expected), 32'd1);
    check_eq("t1_wrap", 32'(wrap_count), 32'd0);

    // 2: three full laps while locked
    se_seen = 0;
    for (int lap = 0; lap < 3; lap++)
      for (int i = 1; i <= 4; i++) begin
        step(1'b1, 2'(i), 1'b0);
        se_seen += int'(seq_error);
      end
    check_eq("t2_wrap", 32'(wrap_count), 32'd3);
    check_eq("t2_no_seq_error", 32'(se_seen), 32'd0);

    // 3: single slip and recovery
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    check_eq("t3_seq_error", 32'(seq_error), 32'd1);
    check_eq("t3_slip_locked", 32'(locked), 32'd1);
    step(1'b1, 2'd1, 1'b0);
    check_eq("t3_expected", 32'(expected), 32'd2);
    check_eq("t3_err", 32'(err_count), 32'd1);

    // 4: two consecutive mismatches drop lock; five samples relock
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    check_eq("t4_unlocked", 32'(locked), 32'd0);
    check_eq("t4_err", 32'(err_count), 32'd3);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'(i), 1'b0);
      if (i == 4) check_eq("t4_relock_early", 32'(locked), 32'd0);
    end
    check_eq("t4_relocked", 32'(locked), 32'd1);

    // 5: idle cycles, then asynchronous reset while locked
    step(1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'(i), 1'b0);
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_locked", 32'(locked), 32'd0);
    check_eq("t5_async_err", 32'(err_count), 32'd0);
    check_eq("t5_async_wrap", 32'(wrap_count), 32'd0);
    check_eq("t5_async_expected", 32'(expected), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 6: saturate err_count, then clear together with an error
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 1'b0);
    l = 2'd0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, l, 1'b0);
      l = 2'(l + 2'd1);
      step(1'b1, l, 1'b0);
    end
    check_eq("t6_err_sat", 32'(err_count), 32'd255);
    step(1'b1, l, 1'b1);
    check_eq("t6_clear_wins", 32'(err_count), 32'd0);
`ifdef STICKY_ERR_EN
    check_eq("t6_sticky_cleared", 32'(err_sticky), 32'd0);
`endif

    // random mix: mostly in-sequence with noise, gaps and clears
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 9) < 8) ? 2'(m_last + 2'd1) : 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 49) == 0);
      step(v, s, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
